// File: rtl/switch_debounce.sv
// switch_debounce: synchronise and debounce raw switch levels, with edge strobes
// Ports:
//   clk     - system clock, all state on rising edge
//   reset_n - asynchronous active-low reset
//   sw_in   - raw, asynchronous, bouncing switch levels
//   sw_db   - debounced level per bit (decoded from registered state)
//   sw_rise - one-cycle strobe when sw_db goes 0->1
//   sw_fall - one-cycle strobe when sw_db goes 1->0
module switch_debounce #(
  parameter int WIDTH     = 2,
  parameter int TICK_BITS = 19,
  parameter int CONFIRM   = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
);
  typedef enum logic [1:0] {ZERO = 2'b00, WAIT1 = 2'b01, ONE = 2'b10, WAIT0 = 2'b11} state_t;
  localparam logic [3:0] LAST = 4'(CONFIRM - 1);
  logic [WIDTH-1:0]     s1, s2;
  logic [TICK_BITS-1:0] pre;
  logic                 tick;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1  <= '0;
      s2  <= '0;
      pre <= '0;
    end else begin
      s1  <= sw_in;
      s2  <= s1;
      pre <= pre + 1'b1;
    end
  assign tick = &pre;
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      state_t     st;
      logic [3:0] cnt;
      logic       rise, fall;
      // a level reversal is checked before the tick so it always wins
      always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
          st   <= ZERO;
          cnt  <= '0;
          rise <= 1'b0;
          fall <= 1'b0;
        end else begin
          rise <= 1'b0;
          fall <= 1'b0;
          case (st)
            ZERO:
              if (s2[i]) begin
                st  <= WAIT1;
                cnt <= '0;
              end
            WAIT1:
              if (!s2[i]) st <= ZERO;
              else if (tick) begin
                if (cnt == LAST) begin
                  st   <= ONE;
                  rise <= 1'b1;
                end else cnt <= cnt + 4'd1;
              end
            ONE:
              if (!s2[i]) begin
                st  <= WAIT0;
                cnt <= '0;
              end
            WAIT0:
              if (s2[i]) st <= ONE;
              else if (tick) begin
                if (cnt == LAST) begin
                  st   <= ZERO;
                  fall <= 1'b1;
                end else cnt <= cnt + 4'd1;
              end
            default: st <= ZERO;
          endcase
        end
      assign sw_db[i]   = (st == ONE) || (st == WAIT0);
      assign sw_rise[i] = rise;
      assign sw_fall[i] = fall;
    end
  endgenerate
endmodule
